clk_req_ctrl: RTL and testbench

- Demand-driven, glitch-free gate for one divided system clock, e.g. the 1.8432 MHz UART clock or the 32 kHz clock derived from PCLK (7.3728 MHz).
- Sits between the PCLK divider and its consumers.
- Up to N_REQ peripherals request the clock via REQ/ACK handshakes; the block starts it on demand, holds it through a hold-off window after the last release, then stops it on a low phase.

---
 rtl/clk_req_ctrl.sv | 128 ++++++++++++
 tb/tb_clk_req_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_req_ctrl.sv
// Demand-driven glitch-free gate for a divided clock with REQ/ACK handshakes.
// Optional macro CLKREQ_FORCE_EN adds a FORCE_ON input that keeps the clock running.
module clk_req_ctrl #(
    parameter int                N_REQ   = 4,
    parameter int                HOLD_W  = 12,
    parameter logic [HOLD_W-1:0] HOLDOFF = 12'd256
) (
    input  logic             PCLK,
    input  logic             RST,
    input  logic             CLK_DIV_IN,
    input  logic [N_REQ-1:0] REQ,
`ifdef CLKREQ_FORCE_EN
    input  logic             FORCE_ON,
`endif
    output logic [N_REQ-1:0] ACK,
    output logic             CLK_GATED,
    output logic             CLK_ACTIVE,
    output logic             BUSY
);

    typedef enum logic [2:0] {
        OFF,
        WAIT_ON,
        START,
        RUN,
        HOLD,
        WAIT_OFF
    } state_t;

    localparam logic [HOLD_W-1:0] ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              gate_q, gate_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              div_q;
    logic              gck_q;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              rise;
    logic              any_req;

    assign rise = CLK_DIV_IN & ~div_q;

`ifdef CLKREQ_FORCE_EN
    assign any_req = (|REQ) | FORCE_ON;
`else
    assign any_req = |REQ;
`endif

    // gate_d only moves while the sampled divided clock is low
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            OFF: begin
                if (any_req) state_d = WAIT_ON;
            end
            WAIT_ON: begin
                if (!any_req) begin
                    state_d = OFF;
                end else if (!CLK_DIV_IN) begin
                    gate_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (rise) state_d = RUN;
            end
            RUN: begin
                if (!any_req) begin
                    if (HOLDOFF == '0) begin
                        state_d = WAIT_OFF;
                    end else begin
                        cnt_d   = HOLDOFF - ONE;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (any_req) begin
                    state_d = RUN;
                end else if (cnt_q == '0) begin
                    state_d = WAIT_OFF;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            WAIT_OFF: begin
                if (any_req) begin
                    state_d = RUN;
                end else if (!CLK_DIV_IN) begin
                    gate_d  = 1'b0;
                    state_d = OFF;
                end
            end
            default: begin
                state_d = OFF;
                gate_d  = 1'b0;
            end
        endcase
    end

    assign ack_d = REQ & {N_REQ{state_d == RUN}};

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            state_q <= OFF;
            gate_q  <= 1'b0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            gck_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            div_q   <= CLK_DIV_IN;
            gck_q   <= CLK_DIV_IN & gate_q;
            ack_q   <= ack_d;
        end
    end

    assign ACK        = ack_q;
    assign CLK_GATED  = gck_q;
    assign CLK_ACTIVE = gate_q;
    assign BUSY       = (state_q != OFF);

endmodule

// File: tb/tb_clk_req_ctrl.sv
// Directed bench for clk_req_ctrl: divide-by-8 source clock, HOLDOFF=16.
// Vector table for the basic flows plus hand-written multi-cycle sequences.
module tb_clk_req_ctrl;

    logic       PCLK = 1'b0;
    logic       RST = 1'b1;
    logic       CLK_DIV_IN = 1'b0;
    logic [3:0] REQ = 4'h0;
    logic [3:0] ACK;
    logic       CLK_GATED;
    logic       CLK_ACTIVE;
    logic       BUSY;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [2:0] ph = 3'd0;
    int         hi_len = 0;

    typedef struct {
        logic [3:0] req;
        int         n;
        logic [3:0] ack;
        logic       busy;
        logic       act;
        bit         gchk;
        logic       gck;
    } vec_t;

    vec_t tbl [13];

    clk_req_ctrl #(
        .N_REQ  (4),
        .HOLD_W (12),
        .HOLDOFF(12'd16)
    ) dut (
        .PCLK      (PCLK),
        .RST       (RST),
        .CLK_DIV_IN(CLK_DIV_IN),
        .REQ       (REQ),
`ifdef CLKREQ_FORCE_EN
        .FORCE_ON  (1'b0),
`endif
        .ACK       (ACK),
        .CLK_GATED (CLK_GATED),
        .CLK_ACTIVE(CLK_ACTIVE),
        .BUSY      (BUSY)
    );

    initial forever #5 PCLK = ~PCLK;

    function automatic vec_t mk(logic [3:0] rq, int n, logic [3:0] ak,
                                logic bz, logic ac, bit gc, logic g);
        vec_t v;
        v.req  = rq;
        v.n    = n;
        v.ack  = ak;
        v.busy = bz;
        v.act  = ac;
        v.gchk = gc;
        v.gck  = g;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Source clock behaves like a PCLK register: changes just after the edge
    task automatic tick();
        @(posedge PCLK);
        #1;
        ph = ph + 3'd1;
        CLK_DIV_IN = ph[2];
    endtask

    task automatic check_row(input int r, input int k);
        string s;
        s = $sformatf("row%0d.%0d", r, k);
        check({s, " ack"}, {28'd0, ACK}, {28'd0, tbl[r].ack});
        check({s, " busy"}, {31'd0, BUSY}, {31'd0, tbl[r].busy});
        check({s, " active"}, {31'd0, CLK_ACTIVE}, {31'd0, tbl[r].act});
        if (tbl[r].gchk)
            check({s, " gated"}, {31'd0, CLK_GATED}, {31'd0, tbl[r].gck});
    endtask

    // Every completed CLK_GATED high pulse must be a full 4-cycle phase
    initial forever begin
        @(negedge PCLK);
        if (RST) begin
            hi_len = 0;
        end else if (CLK_GATED) begin
            hi_len++;
        end else if (hi_len != 0) begin
            check("pulse width", hi_len, 4);
            hi_len = 0;
        end
    end

    initial begin
        int   w;
        int   rises;
        logic gp;

        tbl[0]  = mk(4'h0, 106, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[1]  = mk(4'h1, 1,   4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[2]  = mk(4'h1, 2,   4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[3]  = mk(4'h1, 4,   4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[4]  = mk(4'h1, 1,   4'h1, 1'b1, 1'b1, 1'b1, 1'b1);
        tbl[5]  = mk(4'h1, 10,  4'h1, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[6]  = mk(4'h0, 1,   4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        tbl[7]  = mk(4'h0, 16,  4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[8]  = mk(4'h0, 1,   4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[9]  = mk(4'h0, 3,   4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[10] = mk(4'h4, 2,   4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[11] = mk(4'h0, 1,   4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[12] = mk(4'h0, 12,  4'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (3) tick();
        check("rst ack", {28'd0, ACK}, 32'd0);
        check("rst gated", {31'd0, CLK_GATED}, 32'd0);
        check("rst active", {31'd0, CLK_ACTIVE}, 32'd0);
        check("rst busy", {31'd0, BUSY}, 32'd0);
        RST = 1'b0;

        for (int r = 0; r < 13; r++) begin
            REQ = tbl[r].req;
            for (int k = 0; k < tbl[r].n; k++) begin
                tick();
                check_row(r, k);
            end
        end

        // Re-request in HOLD at counter 5: clock must not skip a pulse
        REQ = 4'h1;
        w = 0;
        while (ACK[0] !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("s4 start latency", w, 10);
        REQ = 4'h0;
        rises = 0;
        gp = CLK_GATED;
        for (int t = 1; t <= 32; t++) begin
            if (t == 12) REQ = 4'h2;
            tick();
            if (CLK_GATED && !gp) rises++;
            gp = CLK_GATED;
            if (t == 11) check("s4 ack before", {28'd0, ACK}, 32'd0);
            if (t == 12) check("s4 ack1", {28'd0, ACK}, 32'h2);
        end
        check("s4 rises", rises, 4);
        check("s4 busy", {31'd0, BUSY}, 32'd1);

        REQ = 4'h3;
        tick();
        check("ack add", {28'd0, ACK}, 32'h3);
        REQ = 4'h2;
        tick();
        check("ack drop", {28'd0, ACK}, 32'h2);

        // Hold expiry lands on the last low sample: off 6 cycles later
        repeat (4) tick();
        REQ = 4'h0;
        w = 0;
        while (BUSY && w < 40) begin
            tick();
            w++;
        end
        check("hold off latency", w, 22);

        // Async reset mid high phase, then restart with REQ held
        REQ = 4'h1;
        w = 0;
        while (!(ACK[0] === 1'b1 && CLK_GATED === 1'b1) && w < 20) begin
            tick();
            w++;
        end
        check("s6 run latency", w, 4);
        RST = 1'b1;
        #1;
        check("s6 rst ack", {28'd0, ACK}, 32'd0);
        check("s6 rst gated", {31'd0, CLK_GATED}, 32'd0);
        check("s6 rst active", {31'd0, CLK_ACTIVE}, 32'd0);
        check("s6 rst busy", {31'd0, BUSY}, 32'd0);
        repeat (2) tick();
        RST = 1'b0;
        tick();
        check("s6 busy after rst", {31'd0, BUSY}, 32'd1);
        w = 1;
        while (ACK[0] !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("s6 restart latency", w, 6);
        check("s6 gated at ack", {31'd0, CLK_GATED}, 32'd1);
        check("s6 active at ack", {31'd0, CLK_ACTIVE}, 32'd1);

        REQ = 4'h0;
        tick();
        check("final ack", {28'd0, ACK}, 32'd0);
        repeat (30) tick();
        check("final busy", {31'd0, BUSY}, 32'd0);
        check("final active", {31'd0, CLK_ACTIVE}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
